// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 size/sign codes, LSU FSM
// states and the access-size type.
package riscv_pkg;

  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_D  = 3'b011;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } lsu_size_e;

  // Access size is carried directly in the low two funct3 bits.
  function automatic lsu_size_e fn3_size(input logic [2:0] fn3);
    return lsu_size_e'(fn3[1:0]);
  endfunction

  // Unsigned variants exist only for loads; doubles only on RV64.
  function automatic logic fn3_legal(input logic [2:0] fn3, input logic is_store,
                                     input int xlen);
    case (fn3)
      FN3_B, FN3_H, FN3_W: return 1'b1;
      FN3_D:               return (xlen == 64);
      FN3_BU, FN3_HU:      return !is_store;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: legality/misalignment detection,
// byte enables, store-data replication and load shift/extension.
// The offset is forced down to the access size, so misaligned requests
// land on the naturally aligned container.
module lsu_align
  import riscv_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [2:0]      fn3_i,
  input  logic            is_store_i,
  input  logic [OFFW-1:0] off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            illegal_o,
  output logic            misaligned_o,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  lsu_size_e       size;
  logic [OFFW-1:0] size_mask;
  logic [OFFW-1:0] aoff;
  logic [NB-1:0]   lanes;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  // Decode size, place lanes, replicate store data, extend load data.
  always_comb begin
    size      = fn3_size(fn3_i);
    size_mask = '0;
    lanes     = '0;
    case (size)
      SZ_BYTE:   begin size_mask = OFFW'(0); lanes = NB'(8'h01); end
      SZ_HALF:   begin size_mask = OFFW'(1); lanes = NB'(8'h03); end
      SZ_WORD:   begin size_mask = OFFW'(3); lanes = NB'(8'h0F); end
      default:   begin size_mask = OFFW'(7); lanes = NB'(8'hFF); end
    endcase
    illegal_o    = !fn3_legal(fn3_i, is_store_i, XLEN);
    misaligned_o = |(off_i & size_mask);
    aoff         = off_i & ~size_mask;
    be_o         = lanes << aoff;

    wdata_o = '0;
    for (int i = 0; i < NB; i++) begin
      wdata_o[8*i +: 8] = wdata_i[8*(i & int'(size_mask)) +: 8];
    end

    shifted = mem_rdata_i >> {aoff, 3'b000};
    keep    = '0;
    for (int b = 0; b < XLEN; b++) begin
      keep[b] = (b < (8 << int'(size)));
    end
    sign    = !fn3_i[2] && (|(shifted & (keep ^ (keep >> 1))));
    rdata_o = (shifted & keep) | ({XLEN{sign}} & ~keep);
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: IDLE -> ACCESS (LATENCY cycles) -> DONE.
// Errors (illegal fn3, and misalignment when LSU_MISALIGN_TRAP_EN is
// defined) skip the memory and go straight to DONE with err.
// Without LSU_MISALIGN_TRAP_EN, misaligned addresses are aligned down.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        fn3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]   mem_be_q, mem_be_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]      fn3_q, fn3_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            idle;
  logic [2:0]      al_fn3;
  logic            al_store;
  logic [OFFW-1:0] al_off;
  logic            al_illegal, al_misaligned, req_err;
  logic [NB-1:0]   al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;
  logic            addr_unused;

  // The aligner sees the live request in IDLE and the captured one later.
  assign idle     = (state_q == ST_IDLE);
  assign al_fn3   = idle ? fn3 : fn3_q;
  assign al_store = idle ? req_store : mem_we_q;
  assign al_off   = idle ? addr[OFFW-1:0] : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .fn3_i        (al_fn3),
    .is_store_i   (al_store),
    .off_i        (al_off),
    .wdata_i      (wdata),
    .mem_rdata_i  (mem_rdata),
    .illegal_o    (al_illegal),
    .misaligned_o (al_misaligned),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = al_illegal | al_misaligned;
`else
  logic misalign_unused;
  assign misalign_unused = al_misaligned;
  assign req_err         = al_illegal;
`endif

  // Address bits above the memory window are ignored (wrap).
  assign addr_unused = ^addr[XLEN-1:MEM_AW+OFFW];

  // State, counter and captured access registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      fn3_q       <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      fn3_q       <= fn3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in ACCESS, respond in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    fn3_d       = fn3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = req_err;
          fn3_d   = fn3;
          off_d   = addr[OFFW-1:0];
          if (req_err) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = 4'(LATENCY - 1);
            mem_addr_d  = addr[MEM_AW+OFFW-1:OFFW];
            mem_be_d    = al_be;
            mem_we_d    = req_store;
            mem_wdata_d = al_wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!mem_we_q) rdata_d = al_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall      = (idle && req_valid) || (state_q == ST_ACCESS);
  assign resp_valid = (state_q == ST_DONE);
  assign err        = (state_q == ST_DONE) && err_q;
  assign rdata      = rdata_q;
  assign mem_en     = (state_q == ST_ACCESS);
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
